// File: rtl/weight_stream_loader_if.sv
// Word-stream handshake between the host/DMA source (master) and the loader (slave).
interface weight_stream_loader_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready
   );
endinterface

// File: rtl/weight_stream_loader.sv
// Streams one conv layer's kernel, bias and MACC coefficient words into the model's
// weight-write port, generating sequential addresses from BASE_ADDR.
module weight_stream_loader #(
   parameter int unsigned KERNEL_0    = 3,
   parameter int unsigned KERNEL_1    = 3,
   parameter int unsigned IN_CHANNEL  = 3,
   parameter int unsigned OUT_CHANNEL = 16,
   parameter logic [31:0] BASE_ADDR   = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   weight_stream_loader_if.slave  s,
   output logic [31:0]            weight_wr_data,
   output logic [31:0]            weight_wr_addr,
   output logic                   weight_wr_en,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned KN = KERNEL_0 * KERNEL_1 * IN_CHANNEL * OUT_CHANNEL;
   localparam int unsigned CW = $clog2(KN + 1);
   localparam logic [CW-1:0] KERN_LAST = CW'(KN - 1);
   localparam logic [CW-1:0] BIAS_LAST = CW'(OUT_CHANNEL - 1);
   localparam logic [31:0]   BIAS_OFS  = 32'(KN);
   localparam logic [31:0]   COEF_OFS  = 32'(KN + OUT_CHANNEL);

   typedef enum logic [2:0] {
      IDLE,
      KERN,
      GAP0,
      BIAS,
      GAP1,
      COEF,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] idx;
   logic [CW-1:0] idx_nxt;
   logic          ready;
   logic          xfer;
   logic [31:0]   offset;
   logic [31:0]   data_nxt;

   assign ready    = (state == KERN) || (state == BIAS) || (state == COEF);
   assign xfer     = s.s_valid && ready;
   assign s.s_ready = ready;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   // Kernel words carry a signed 8-bit weight; bias and coefficient pass through intact.
   assign data_nxt = (state == KERN) ? {{24{s.s_data[7]}}, s.s_data[7:0]} : s.s_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      offset    = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = KERN;
               idx_nxt   = '0;
            end
         end
         KERN: begin
            offset = 32'(idx);
            if (xfer) begin
               if (idx == KERN_LAST) begin
                  state_nxt = GAP0;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         GAP0: state_nxt = BIAS;
         BIAS: begin
            offset = BIAS_OFS + 32'(idx);
            if (xfer) begin
               if (idx == BIAS_LAST) begin
                  state_nxt = GAP1;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         GAP1: state_nxt = COEF;
         COEF: begin
            offset = COEF_OFS;
            if (xfer) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Address and data hold their last values through cycles without a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_wr_en   <= 1'b0;
         weight_wr_addr <= '0;
         weight_wr_data <= '0;
      end else begin
         weight_wr_en <= xfer;
         if (xfer) begin
            weight_wr_addr <= BASE_ADDR + offset;
            weight_wr_data <= data_nxt;
         end
      end
   end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Randomized scoreboard bench: two loaders (BASE_ADDR 0 and 0x1000) share one stream
// and are checked against a word-count model of the load sequence.
module tb_weight_stream_loader;

   localparam int unsigned KN    = 432;
   localparam int unsigned OC    = 16;
   localparam int unsigned LAST  = KN + OC;
   localparam logic [31:0] BASE1 = 32'h1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;

   logic [31:0] d0, a0, d1, a1;
   logic        en0, en1, busy0, busy1, done0, done1;

   always #5 clk = ~clk;

   weight_stream_loader_if sif0 ();
   weight_stream_loader_if sif1 ();

   assign sif0.s_data  = s_data;
   assign sif0.s_valid = s_valid;
   assign sif1.s_data  = s_data;
   assign sif1.s_valid = s_valid;

   weight_stream_loader dut0 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .s              (sif0.slave),
      .weight_wr_data (d0),
      .weight_wr_addr (a0),
      .weight_wr_en   (en0),
      .busy           (busy0),
      .done           (done0)
   );

   weight_stream_loader #(.BASE_ADDR(BASE1)) dut1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .s              (sif1.slave),
      .weight_wr_data (d1),
      .weight_wr_addr (a1),
      .weight_wr_en   (en1),
      .busy           (busy1),
      .done           (done1)
   );

   typedef struct {
      int unsigned off;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   xfer_cnt = 0;
   int   seen_cnt = 0;
   int   done_cnt = 0;
   int   runs_done = 0;
   int   start_cyc = 0;
   int   last_wr_cyc = 0;
   bit   cont_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Reference: word k of a load goes to offset k; kernel words keep only a signed byte.
   function automatic logic [31:0] model(input int unsigned k, input logic [31:0] w);
      int v;
      if (k < KN) begin
         v = $signed(w[7:0]);
         return 32'(v);
      end
      return w;
   endfunction

   function automatic logic [31:0] gen(input int unsigned k, input bit rnd);
      if (!rnd) return 32'(k);
      if (k == 0)    return 32'h0000_0080;
      if (k == 1)    return 32'hABCD_127F;
      if (k == KN)   return 32'h1234_5678;
      if (k == LAST) return 32'h0000_00AB;
      return $urandom;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: one expected write per transfer issued before this edge.
   always @(posedge clk) begin
      exp_t e;
      bit   pend;
      bit   exp_done;
      #2;
      pend     = (xfer_cnt != seen_cnt);
      exp_done = 1'b0;
      check("wr_en", {31'b0, en0}, {31'b0, pend});
      check("wr_en_base1000", {31'b0, en1}, {31'b0, pend});
      if (pend) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
         end else begin
            e = sbq.pop_front();
            check("wr_addr", a0, e.off);
            check("wr_data", d0, e.data);
            check("wr_addr_base1000", a1, BASE1 + e.off);
            check("wr_data_base1000", d1, e.data);
            exp_done = (e.off == LAST);
            if (e.off == LAST) check("coef_addr_base1000", a1, 32'h0000_11C0);
            if (cont_mode && e.off > 0)
               check("wr_spacing", 32'(cyc - last_wr_cyc),
                     (e.off == KN || e.off == LAST) ? 32'd2 : 32'd1);
            if (cont_mode && exp_done)
               check("load_cycles", 32'(cyc - start_cyc), 32'(LAST + 4));
            last_wr_cyc = cyc;
         end
      end
      seen_cnt = xfer_cnt;
      check("done", {31'b0, done0}, {31'b0, exp_done});
      check("done_base1000", {31'b0, done1}, {31'b0, exp_done});
      if (done0) done_cnt++;
   end

   task automatic run_seq(input bit cont, input bit rnd, input int pulse_at,
                          input int abort_at, input bit start_in_done);
      int unsigned k;
      int          guard;
      @(negedge clk);
      start     = 1'b1;
      s_valid   = 1'b0;
      start_cyc = cyc;
      cont_mode = cont;
      k         = 0;
      guard     = 0;
      while (k <= LAST && guard < 8000) begin
         @(negedge clk);
         guard++;
         start = (pulse_at >= 0 && k == pulse_at);
         if (abort_at >= 0 && k == abort_at + 1) begin
            rst_n   = 1'b0;
            s_valid = 1'b0;
            #1;
            check("abort_wr_en", {31'b0, en0}, 32'd0);
            check("abort_busy", {31'b0, busy0}, 32'd0);
            check("abort_busy_base1000", {31'b0, busy1}, 32'd0);
            check("abort_pending", 32'(sbq.size()), 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         s_valid = cont || ($urandom_range(0, 1) == 1);
         s_data  = gen(k, rnd);
         #1;
         if (s_valid && sif0.s_ready) begin
            sbq.push_back('{k, model(k, s_data)});
            xfer_cnt++;
            k++;
         end
      end
      if (guard >= 8000) begin
         checks++;
         failures++;
         $display("FAIL load_timeout actual=%0d required=%0d", k, LAST + 1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      start   = start_in_done;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("idle_after_done", {31'b0, busy0}, 32'd0);
      runs_done++;
      repeat (3) @(negedge clk);
      check("done_count", 32'(done_cnt), 32'(runs_done));
      check("queue_drained", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      #1;
      check("rst_wr_en", {31'b0, en0}, 32'd0);
      check("rst_wr_addr", a0, 32'd0);
      check("rst_wr_data", d0, 32'd0);
      check("rst_busy", {31'b0, busy0}, 32'd0);
      check("rst_done", {31'b0, done0}, 32'd0);
      check("rst_s_ready", {31'b0, sif0.s_ready}, 32'd0);
      check("rst_wr_addr_base1000", a1, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_seq(1'b1, 1'b0, -1, -1, 1'b0);   // continuous, s_data = n
      run_seq(1'b1, 1'b1, -1, -1, 1'b1);   // directed edge values, start during DONE
      run_seq(1'b0, 1'b0, -1, -1, 1'b0);   // ~50% s_valid gaps
      run_seq(1'b0, 1'b1, 100, -1, 1'b0);  // start while busy
      run_seq(1'b1, 1'b1, -1, 200, 1'b0);  // reset after kernel word 200
      run_seq(1'b1, 1'b1, -1, -1, 1'b0);   // restart from base after abort

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
